// File: rtl/decode_pkg.sv
// Shared encodings and the control-bundle type for the decode stage.
package decode_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    // ALU control encodings
    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_MULTU = 3'b011;
    localparam logic [2:0] ALU_MFHI  = 3'b100;
    localparam logic [2:0] ALU_MFLO  = 3'b101;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_SLTU  = 3'b111;

    // Branch types, resolved later in EX
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BLTZ = 2'b10;

    typedef struct packed {
        logic       memtoreg;
        logic       memwrite;
        logic       alusrcbimm;
        logic       regwrite;
        logic       dojump;
        logic       dojal;
        logic       orimm;
        logic       lui;
        logic [1:0] branch_type;
        logic [4:0] destreg;
        logic [2:0] alucontrol;
        logic       illegal;
    } ctrl_t;

    // True for operations that touch the HI/LO pair.
    function automatic logic uses_hilo(input logic [2:0] alu);
        return (alu == ALU_MULTU) || (alu == ALU_MFHI) || (alu == ALU_MFLO);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// IF -> decode -> EX handshake plus the registered control bundle.
interface decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        memtoreg;
    logic        memwrite;
    logic        alusrcbimm;
    logic        regwrite;
    logic        dojump;
    logic        dojal;
    logic        orimm;
    logic        lui;
    logic [1:0]  branch_type;
    logic [4:0]  destreg;
    logic [2:0]  alucontrol;
    logic        illegal;
    logic        mult_busy;

    // Surrounding pipeline (IF producer / EX consumer)
    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, memtoreg, memwrite, alusrcbimm, regwrite,
               dojump, dojal, orimm, lui, branch_type, destreg, alucontrol,
               illegal, mult_busy
    );

    // Decode stage
    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, memtoreg, memwrite, alusrcbimm, regwrite,
               dojump, dojal, orimm, lui, branch_type, destreg, alucontrol,
               illegal, mult_busy
    );
endinterface

// File: rtl/decode_logic.sv
// Combinational MIPS-subset decoder: instruction fields -> control bundle.
// Unsupported encodings yield an all-zero bundle with only illegal set.
module decode_logic
    import decode_pkg::*;
#(
    parameter bit HAS_JAL     = 1'b1,
    parameter bit HAS_LUI_ORI = 1'b1
) (
    input  logic [5:0] opcode,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    logic bad;

    // Decode opcode/funct; an illegal result overrides everything else.
    always_comb begin
        ctrl = '0;
        bad  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.regwrite = 1'b1;
                ctrl.destreg  = rd;
                case (funct)
                    F_ADDU:  ctrl.alucontrol = ALU_ADD;
                    F_SUBU:  ctrl.alucontrol = ALU_SUB;
                    F_AND:   ctrl.alucontrol = ALU_AND;
                    F_OR:    ctrl.alucontrol = ALU_OR;
                    F_SLTU:  ctrl.alucontrol = ALU_SLTU;
                    F_MULTU: ctrl.alucontrol = ALU_MULTU;
                    F_MFHI:  ctrl.alucontrol = ALU_MFHI;
                    F_MFLO:  ctrl.alucontrol = ALU_MFLO;
                    default: bad = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl.regwrite   = 1'b1;
                ctrl.memtoreg   = 1'b1;
                ctrl.alusrcbimm = 1'b1;
                ctrl.alucontrol = ALU_ADD;
                ctrl.destreg    = rt;
            end
            OP_SW: begin
                ctrl.memwrite   = 1'b1;
                ctrl.alusrcbimm = 1'b1;
                ctrl.alucontrol = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl.branch_type = BR_BEQ;
                ctrl.alucontrol  = ALU_SUB;
            end
            OP_BLTZ: begin
                ctrl.branch_type = BR_BLTZ;
                ctrl.alucontrol  = ALU_SLTU;
            end
            OP_ADDIU: begin
                ctrl.regwrite   = 1'b1;
                ctrl.alusrcbimm = 1'b1;
                ctrl.alucontrol = ALU_ADD;
                ctrl.destreg    = rt;
            end
            OP_ORI: begin
                if (HAS_LUI_ORI) begin
                    ctrl.regwrite   = 1'b1;
                    ctrl.alusrcbimm = 1'b1;
                    ctrl.orimm      = 1'b1;
                    ctrl.alucontrol = ALU_OR;
                    ctrl.destreg    = rt;
                end else begin
                    bad = 1'b1;
                end
            end
            OP_LUI: begin
                if (HAS_LUI_ORI) begin
                    ctrl.regwrite   = 1'b1;
                    ctrl.alusrcbimm = 1'b1;
                    ctrl.lui        = 1'b1;
                    ctrl.alucontrol = ALU_OR;
                    ctrl.destreg    = rt;
                end else begin
                    bad = 1'b1;
                end
            end
            OP_J: begin
                ctrl.dojump = 1'b1;
            end
            OP_JAL: begin
                if (HAS_JAL) begin
                    ctrl.dojal    = 1'b1;
                    ctrl.dojump   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.destreg  = 5'd31;
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: one-entry valid/ready output register, HI/LO
// multiply scoreboard that stalls multu/mfhi/mflo, and EX flush.
module decode_stage
    import decode_pkg::*;
#(
    parameter int MULT_LAT    = 4,     // must be >= 1
    parameter bit HAS_JAL     = 1'b1,
    parameter bit HAS_LUI_ORI = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    decode_stage_if.slave bus
);

    localparam int             CW     = $clog2(MULT_LAT + 1);
    localparam logic [CW-1:0]  LAT_LD = CW'(MULT_LAT);

    ctrl_t          dec_p0;
    ctrl_t          ctrl_p1;
    logic           vld_p1;
    logic [CW-1:0]  mult_cnt;
    logic           busy;
    logic           hazard;
    logic           accept;
    logic           ex_take;
    logic           unused_instr_bits;

    // rs and shamt are not needed to form the control bundle.
    assign unused_instr_bits = ^{bus.instr[25:21], bus.instr[10:6]};

    // ---- p0: combinational decode of the presented instruction ----
    decode_logic #(
        .HAS_JAL     (HAS_JAL),
        .HAS_LUI_ORI (HAS_LUI_ORI)
    ) u_decode_logic (
        .opcode (bus.instr[31:26]),
        .rt     (bus.instr[20:16]),
        .rd     (bus.instr[15:11]),
        .funct  (bus.instr[5:0]),
        .ctrl   (dec_p0)
    );

    // HI/LO is busy while the multiplier runs or a multu is waiting to leave.
    assign busy    = (mult_cnt != '0) || (vld_p1 && (ctrl_p1.alucontrol == ALU_MULTU));
    assign hazard  = bus.in_valid && uses_hilo(dec_p0.alucontrol) && busy;
    assign bus.in_ready = reset && !bus.flush && !hazard && (!vld_p1 || bus.out_ready);
    assign accept  = bus.in_valid && bus.in_ready;
    assign ex_take = vld_p1 && bus.out_ready && !bus.flush;

    // ---- p1: output register; capture, or retire/kill the held bundle ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            ctrl_p1 <= dec_p0;
        end else if (bus.out_ready || bus.flush) begin
            vld_p1  <= 1'b0;
        end
    end

    // Scoreboard counter: reload when a multu enters EX, else run down to zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mult_cnt <= '0;
        end else if (ex_take && (ctrl_p1.alucontrol == ALU_MULTU)) begin
            mult_cnt <= LAT_LD;
        end else if (mult_cnt != '0) begin
            mult_cnt <= mult_cnt - CW'(1);
        end
    end

    assign bus.out_valid   = vld_p1;
    assign bus.memtoreg    = ctrl_p1.memtoreg;
    assign bus.memwrite    = ctrl_p1.memwrite;
    assign bus.alusrcbimm  = ctrl_p1.alusrcbimm;
    assign bus.regwrite    = ctrl_p1.regwrite;
    assign bus.dojump      = ctrl_p1.dojump;
    assign bus.dojal       = ctrl_p1.dojal;
    assign bus.orimm       = ctrl_p1.orimm;
    assign bus.lui         = ctrl_p1.lui;
    assign bus.branch_type = ctrl_p1.branch_type;
    assign bus.destreg     = ctrl_p1.destreg;
    assign bus.alucontrol  = ctrl_p1.alucontrol;
    assign bus.illegal     = ctrl_p1.illegal;
    assign bus.mult_busy   = busy;

endmodule

// File: tb/tb_decode_stage.sv
// Directed, table-driven bench for decode_stage (default build plus a
// build without jal/lui/ori sharing the same stimulus).
module tb_decode_stage;

    logic clk;
    logic reset;

    decode_stage_if b1();
    decode_stage_if b2();

    decode_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    decode_stage #(
        .MULT_LAT    (4),
        .HAS_JAL     (1'b0),
        .HAS_LUI_ORI (1'b0)
    ) u_dut_min (
        .clk   (clk),
        .reset (reset),
        .bus   (b2.slave)
    );

    assign b2.in_valid  = b1.in_valid;
    assign b2.instr     = b1.instr;
    assign b2.flush     = b1.flush;
    assign b2.out_ready = b1.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {memtoreg,memwrite,alusrcbimm,regwrite,dojump,dojal,orimm,lui,bt[1:0],destreg[4:0],alu[2:0],illegal}
    logic [18:0] act1, act2;
    assign act1 = {b1.memtoreg, b1.memwrite, b1.alusrcbimm, b1.regwrite, b1.dojump, b1.dojal,
                   b1.orimm, b1.lui, b1.branch_type, b1.destreg, b1.alucontrol, b1.illegal};
    assign act2 = {b2.memtoreg, b2.memwrite, b2.alusrcbimm, b2.regwrite, b2.dojump, b2.dojal,
                   b2.orimm, b2.lui, b2.branch_type, b2.destreg, b2.alucontrol, b2.illegal};

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [18:0] eb(input logic mtr, input logic mw, input logic asi,
                                       input logic rw, input logic dj, input logic djal,
                                       input logic ori, input logic lu, input logic [1:0] bt,
                                       input logic [4:0] dr, input logic [2:0] alu,
                                       input logic ill);
        return {mtr, mw, asi, rw, dj, djal, ori, lu, bt, dr, alu, ill};
    endfunction

    function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, 5'd4, 5'd5, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rt);
        return {op, 5'd6, rt, 16'h1234};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    localparam logic [18:0] LW_B  = {1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,5'd8,3'b010,1'b0};
    localparam logic [18:0] SW_B  = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,5'd0,3'b010,1'b0};
    localparam logic [18:0] ILL_B = {18'd0, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"addu",  32'h00851021,            eb(0,0,0,1,0,0,0,0,2'b00,5'd2, 3'b010,0)};
        vecs[1]  = '{"subu",  mk_r(5'd5, 6'b100011),   eb(0,0,0,1,0,0,0,0,2'b00,5'd5, 3'b110,0)};
        vecs[2]  = '{"and",   mk_r(5'd7, 6'b100100),   eb(0,0,0,1,0,0,0,0,2'b00,5'd7, 3'b000,0)};
        vecs[3]  = '{"or",    mk_r(5'd9, 6'b100101),   eb(0,0,0,1,0,0,0,0,2'b00,5'd9, 3'b001,0)};
        vecs[4]  = '{"sltu",  mk_r(5'd31,6'b101011),   eb(0,0,0,1,0,0,0,0,2'b00,5'd31,3'b111,0)};
        vecs[5]  = '{"mfhi",  mk_r(5'd3, 6'b010000),   eb(0,0,0,1,0,0,0,0,2'b00,5'd3, 3'b100,0)};
        vecs[6]  = '{"mflo",  mk_r(5'd4, 6'b010010),   eb(0,0,0,1,0,0,0,0,2'b00,5'd4, 3'b101,0)};
        vecs[7]  = '{"rbad",  mk_r(5'd6, 6'b000000),   ILL_B};
        vecs[8]  = '{"lw",    mk_i(6'b100011, 5'd8),   LW_B};
        vecs[9]  = '{"sw",    mk_i(6'b101011, 5'd8),   SW_B};
        vecs[10] = '{"beq",   mk_i(6'b000100, 5'd3),   eb(0,0,0,0,0,0,0,0,2'b01,5'd0, 3'b110,0)};
        vecs[11] = '{"bltz",  mk_i(6'b000001, 5'd0),   eb(0,0,0,0,0,0,0,0,2'b10,5'd0, 3'b111,0)};
        vecs[12] = '{"addiu", mk_i(6'b001001, 5'd10),  eb(0,0,1,1,0,0,0,0,2'b00,5'd10,3'b010,0)};
        vecs[13] = '{"ori",   mk_i(6'b001101, 5'd11),  eb(0,0,1,1,0,0,1,0,2'b00,5'd11,3'b001,0)};
        vecs[14] = '{"lui",   mk_i(6'b001111, 5'd12),  eb(0,0,1,1,0,0,0,1,2'b00,5'd12,3'b001,0)};
        vecs[15] = '{"j",     {6'b000010, 26'h0000100}, eb(0,0,0,0,1,0,0,0,2'b00,5'd0, 3'b000,0)};
        vecs[16] = '{"jal",   {6'b000011, 26'h0000100}, eb(0,0,0,1,1,1,0,0,2'b00,5'd31,3'b000,0)};
        vecs[17] = '{"op3f",  {6'b111111, 26'h0000000}, ILL_B};

        // Reset
        reset        = 1'b0;
        b1.in_valid  = 1'b0;
        b1.instr     = 32'h0;
        b1.flush     = 1'b0;
        b1.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", {31'd0, b1.out_valid}, 32'd0);
        chk("rst_bundle",    {13'd0, act1}, 32'd0);
        chk("rst_mult_busy", {31'd0, b1.mult_busy}, 32'd0);
        b1.in_valid  = 1'b1;
        b1.instr     = 32'h00851021;
        settle();
        chk("rst_in_ready", {31'd0, b1.in_ready}, 32'd0);
        reset = 1'b1;

        // Table of single-instruction decodes, streamed back to back
        b1.out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            b1.in_valid = 1'b1;
            b1.instr    = vecs[i].instr;
            settle();
            chk({vecs[i].name, "_in_ready"}, {31'd0, b1.in_ready}, 32'd1);
            tick();
            chk({vecs[i].name, "_out_valid"}, {31'd0, b1.out_valid}, 32'd1);
            chk({vecs[i].name, "_bundle"}, {13'd0, act1}, {13'd0, vecs[i].exp});
        end
        b1.in_valid = 1'b0;
        tick();
        chk("drain_out_valid", {31'd0, b1.out_valid}, 32'd0);

        // multu followed by mfhi: stall for MULT_LAT cycles after EX takes multu
        b1.in_valid = 1'b1;
        b1.instr    = mk_r(5'd0, 6'b011001);
        tick();
        chk("multu_alu", {29'd0, b1.alucontrol}, 32'd3);
        chk("multu_held_busy", {31'd0, b1.mult_busy}, 32'd1);
        b1.instr = mk_r(5'd3, 6'b010000);
        settle();
        chk("mfhi_hazard_held", {31'd0, b1.in_ready}, 32'd0);
        tick();
        chk("multu_gone_valid", {31'd0, b1.out_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mfhi_stall_%0d", k), {31'd0, b1.in_ready}, 32'd0);
            chk($sformatf("busy_stall_%0d", k), {31'd0, b1.mult_busy}, 32'd1);
            tick();
        end
        chk("mfhi_release", {31'd0, b1.in_ready}, 32'd1);
        chk("busy_release", {31'd0, b1.mult_busy}, 32'd0);
        tick();
        chk("mfhi_captured", {31'd0, b1.out_valid}, 32'd1);
        chk("mfhi_alu", {29'd0, b1.alucontrol}, 32'd4);
        b1.in_valid = 1'b0;
        tick();

        // Back-pressure: lw held while sw waits
        b1.in_valid  = 1'b1;
        b1.instr     = mk_i(6'b100011, 5'd8);
        b1.out_ready = 1'b0;
        tick();
        b1.instr = mk_i(6'b101011, 5'd8);
        settle();
        chk("sw_blocked", {31'd0, b1.in_ready}, 32'd0);
        tick();
        chk("lw_hold1_valid", {31'd0, b1.out_valid}, 32'd1);
        chk("lw_hold1", {13'd0, act1}, {13'd0, LW_B});
        tick();
        chk("lw_hold2", {13'd0, act1}, {13'd0, LW_B});
        b1.out_ready = 1'b1;
        settle();
        chk("sw_unblocked", {31'd0, b1.in_ready}, 32'd1);
        tick();
        chk("sw_valid", {31'd0, b1.out_valid}, 32'd1);
        chk("sw_bundle", {13'd0, act1}, {13'd0, SW_B});
        b1.in_valid = 1'b0;
        tick();

        // Flush kills the held beq and blocks a simultaneous capture
        b1.in_valid  = 1'b1;
        b1.instr     = mk_i(6'b000100, 5'd3);
        b1.out_ready = 1'b0;
        tick();
        chk("beq_held_bt", {30'd0, b1.branch_type}, 32'd1);
        b1.flush     = 1'b1;
        b1.out_ready = 1'b1;
        b1.instr     = mk_i(6'b001001, 5'd10);
        settle();
        chk("flush_in_ready", {31'd0, b1.in_ready}, 32'd0);
        tick();
        b1.flush    = 1'b0;
        b1.in_valid = 1'b0;
        chk("flush_out_valid", {31'd0, b1.out_valid}, 32'd0);
        chk("flush_no_capture_bt", {30'd0, b1.branch_type}, 32'd1);
        chk("flush_no_capture_rw", {31'd0, b1.regwrite}, 32'd0);

        // Flushed multu never starts the multiplier
        b1.in_valid  = 1'b1;
        b1.instr     = mk_r(5'd0, 6'b011001);
        b1.out_ready = 1'b0;
        tick();
        b1.in_valid  = 1'b0;
        b1.flush     = 1'b1;
        b1.out_ready = 1'b1;
        tick();
        b1.flush = 1'b0;
        chk("fmultu_valid", {31'd0, b1.out_valid}, 32'd0);
        chk("fmultu_busy", {31'd0, b1.mult_busy}, 32'd0);
        tick();
        chk("fmultu_busy2", {31'd0, b1.mult_busy}, 32'd0);

        // jal / lui on the build that lacks them
        b1.in_valid = 1'b1;
        b1.instr    = {6'b000011, 26'h0000040};
        tick();
        chk("jal_full", {13'd0, act1}, {13'd0, vecs[16].exp});
        chk("jal_min_valid", {31'd0, b2.out_valid}, 32'd1);
        chk("jal_min_illegal", {13'd0, act2}, {13'd0, ILL_B});
        b1.instr = mk_i(6'b001111, 5'd12);
        tick();
        chk("lui_min_illegal", {13'd0, act2}, {13'd0, ILL_B});
        b1.instr = mk_i(6'b001101, 5'd11);
        tick();
        chk("ori_min_illegal", {13'd0, act2}, {13'd0, ILL_B});
        b1.instr = mk_i(6'b001001, 5'd10);
        tick();
        chk("addiu_min", {13'd0, act2}, {13'd0, vecs[12].exp});
        b1.in_valid = 1'b0;
        tick();

        // Reset in the middle of a multiply window
        b1.in_valid = 1'b1;
        b1.instr    = mk_r(5'd0, 6'b011001);
        tick();
        b1.in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_busy", {31'd0, b1.mult_busy}, 32'd1);
        reset       = 1'b0;
        b1.in_valid = 1'b1;
        b1.instr    = mk_r(5'd3, 6'b010000);
        settle();
        chk("midrst_in_ready", {31'd0, b1.in_ready}, 32'd0);
        tick();
        chk("midrst_valid", {31'd0, b1.out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, b1.mult_busy}, 32'd0);
        reset = 1'b1;
        settle();
        chk("postrst_in_ready", {31'd0, b1.in_ready}, 32'd1);
        tick();
        chk("postrst_mfhi_valid", {31'd0, b1.out_valid}, 32'd1);
        chk("postrst_mfhi_alu", {29'd0, b1.alucontrol}, 32'd4);
        b1.in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, pipelined successor to the combinational MIPS control decoder. Sits between the fetch stage (IF) and the execute stage (EX).
- Accepts one 32-bit instruction per valid/ready handshake and holds the decoded control bundle in a single output register.
- Branch resolution moves out of decode: the stage emits a branch type, and EX evaluates the condition.
- Adds an HI/LO multiply scoreboard that stalls mfhi/mflo/multu while the multiplier is busy, a flush input, and an explicit illegal-instruction flag instead of X outputs.

Parameters:
- MULT_LAT, 4: cycles the multiplier occupies HI/LO after a multu leaves this stage. Must be >= 1.
- HAS_JAL, 1: when 0, opcode 000011 decodes as illegal.
- HAS_LUI_ORI, 1: when 0, opcodes 001111 and 001101 decode as illegal.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- instr  in  32  instruction word.
- flush  in  1  EX redirect; kills the held instruction.
- out_valid  out  1  control bundle valid.
- out_ready  in  1  EX accepts the bundle.
- memtoreg, memwrite, alusrcbimm, regwrite, dojump, dojal, orimm, lui  out  1 each  registered control bits.
- branch_type  out  2  00 none, 01 beq, 10 bltz.
- destreg  out  5  destination register number.
- alucontrol  out  3  000 and, 001 or, 010 add, 011 multu, 100 mfhi, 101 mflo, 110 sub, 111 sltu.
- illegal  out  1  unsupported opcode or funct.
- mult_busy  out  1  scoreboard busy.

Behaviour:
- Reset (reset==0 at a clk edge): out_valid=0, mult counter=0, and all bundle outputs=0. in_ready is 0 during the reset cycle.
- Latency: instruction accepted at edge N appears with out_valid=1 after edge N. There is one entry, no skid buffer.
- Opcode decode:
  - 000000 (R-type): regwrite=1, destreg=instr[15:11].
  - R-type funct→alucontrol: 100001→010, 100011→110, 100100→000, 100101→001, 101011→111, 011001→011, 010000→100, 010010→101. Any other funct sets illegal.
  - 100011 lw: regwrite=1, memtoreg=1, alusrcbimm=1, alu add, destreg=instr[20:16].
  - 101011 sw: memwrite=1, alusrcbimm=1, alu add, regwrite=0.
  - 000100 beq: branch_type=01, alu sub.
  - 000001 bltz: branch_type=10, alu sltu (111).
  - 001001 addiu: regwrite=1, alusrcbimm=1, add, destreg=instr[20:16].
  - 001101 ori: regwrite=1, alusrcbimm=1, orimm=1, alu or, memwrite=0.
  - 001111 lui: regwrite=1, alusrcbimm=1, lui=1, alu or.
  - 000010 j: dojump=1.
  - 000011 jal: dojal=1, dojump=1, regwrite=1, destreg=31.
- Illegal instructions: every bundle bit is 0 except illegal=1. destreg=0 whenever regwrite=0; there are no X outputs.
- Scoreboard:
  - The counter loads MULT_LAT on the EX handshake (out_valid&&out_ready&&!flush) of a multu. Otherwise it decrements each cycle while nonzero.
  - mult_busy = (counter!=0) || (out_valid && held alucontrol==011).
- Hazard: hazard = in_valid && instr decodes to multu/mfhi/mflo && mult_busy.
- in_ready = reset && !flush && !hazard && (!out_valid || out_ready).
- Output register:
  - Loads on in_valid&&in_ready.
  - Otherwise clears out_valid on out_ready or flush.
  - Bundle bits hold their value while stalled.
- Simultaneous events:
  - flush and out_ready in the same cycle: no transfer, counter not loaded, out_valid→0.
  - flush and in_valid in the same cycle: nothing is captured.
  - Counter at 1 with a new multu handshake: the counter reloads to MULT_LAT.
- Reset mid-multiply: the counter clears and the stall releases on the next cycle.

Decomposition:
- Package decode_pkg: opcode and funct localparams, alucontrol encodings, branch_type encodings, and a packed control-bundle struct.
- Sub-module decode_logic: purely combinational instr→bundle+illegal, parametrised by HAS_JAL/HAS_LUI_ORI.
- decode_stage holds the handshake register, the scoreboard counter ($clog2(MULT_LAT+1) bits) and the stall logic.

Test Plan:
- Reset then addu instr=0x00851021 with out_ready=1 → next cycle out_valid=1, regwrite=1, destreg=2, alucontrol=010, illegal=0.
- multu (funct 011001) handshaken, then mfhi presented, MULT_LAT=4 → in_ready=0 for 4 cycles after the handshake. mfhi is captured on the 5th edge, alucontrol=100.
- Hold out_ready=0 with lw in the register, present sw → in_ready=0 and the lw bundle stays stable. Raise out_ready → lw transfers, sw is captured the same edge, then memwrite=1, regwrite=0.
- beq in the register, flush=1 with out_ready=1 → out_valid=0 next cycle. A new in_valid in the flush cycle is ignored. A flushed multu leaves mult_busy=0.
- opcode 0x3F, and HAS_JAL=0 with jal → illegal=1, regwrite=0, memwrite=0, dojump=0, destreg=0.
- reset asserted 2 cycles into a multu busy window → counter=0, out_valid=0. mfhi accepted in the first cycle after reset release.
